// File: rtl/sccb_init_seq_if.sv
// Request/response bundle between the camera init sequencer (master) and an SCCB
// bus engine (slave).
//
// Handshake: the master raises sccb_start together with sccb_rw, sccb_ip_addr,
// sccb_sub_addr and sccb_data_in, and holds all of them stable until it samples
// the slave's one-cycle sccb_done pulse. sccb_data_out is valid only while
// sccb_done is high. The master drops sccb_start on the cycle after sccb_done.
interface sccb_init_seq_if;
  logic       sccb_start;
  logic       sccb_rw;
  logic [7:0] sccb_ip_addr;
  logic [7:0] sccb_sub_addr;
  logic [7:0] sccb_data_in;
  logic [7:0] sccb_data_out;
  logic       sccb_done;

  modport master (
    output sccb_start, sccb_rw, sccb_ip_addr, sccb_sub_addr, sccb_data_in,
    input  sccb_data_out, sccb_done
  );

  modport slave (
    input  sccb_start, sccb_rw, sccb_ip_addr, sccb_sub_addr, sccb_data_in,
    output sccb_data_out, sccb_done
  );
endinterface

// File: rtl/sccb_init_seq.sv
// Walks a 32-entry ROM of {op, sub, data} and issues SCCB register writes and ms delays.
// Define SCCB_INIT_READBACK_EN to read back every write and count mismatches in err_cnt.
module sccb_init_seq #(
  parameter int unsigned       XCLK_FREQ  = 50_000_000,
  parameter logic [7:0]        DEV_ADDR   = 8'h60,
  parameter int unsigned       GAP_CYCLES = 1000,
  parameter logic [32*18-1:0]  ROM_IMAGE  = {
    {28{18'h3FFFF}},
    18'h01101,   // 3: W 11,01
    18'h1000A,   // 2: D 10 ms
    18'h01280,   // 1: W 12,80
    18'h0FF01    // 0: W FF,01
  }
) (
  input  logic                    XCLK,
  input  logic                    RST,
  input  logic                    init_start,
  output logic                    init_busy,
  output logic                    init_done,
  output logic [7:0]              err_cnt,
  output logic [3:0]              dbg_state_o,
  sccb_init_seq_if.master         sccb
);

  localparam logic [1:0]  OP_WR        = 2'b00;
  localparam logic [1:0]  OP_DLY       = 2'b01;
  localparam logic [1:0]  OP_END       = 2'b11;
  localparam logic [31:0] TICKS_PER_MS = 32'(XCLK_FREQ / 1000);
  localparam logic [31:0] GAP_LOAD     = 32'(GAP_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_ISSUE     = 4'd2,
    S_WAIT_DONE = 4'd3,
    S_GAP       = 4'd4,
    S_DELAY     = 4'd5,
`ifdef SCCB_INIT_READBACK_EN
    S_RB_ISSUE  = 4'd7,
    S_RB_WAIT   = 4'd8,
    S_RB_GAP    = 4'd9,
`endif
    S_DONE      = 4'd6
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [15:0] ent_q, ent_d;
  logic [31:0] cnt_q, cnt_d;
  logic        start_q, start_d;
  logic        rw_q, rw_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  sub_q, sub_d;
  logic [7:0]  data_q, data_d;
`ifdef SCCB_INIT_READBACK_EN
  logic [7:0]  err_q, err_d;
`endif

  logic [17:0] rom_word;
  logic [1:0]  rom_op;

  // The last slot is always END so the index can never wrap back to 0.
  always_comb begin
    rom_word = ROM_IMAGE[18*32'(idx_q) +: 18];
    if (idx_q == 5'd31) rom_word[17:16] = OP_END;
  end
  assign rom_op = rom_word[17:16];

  always_ff @(posedge XCLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ent_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      sub_q   <= '0;
      data_q  <= '0;
`ifdef SCCB_INIT_READBACK_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ent_q   <= ent_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      sub_q   <= sub_d;
      data_q  <= data_d;
`ifdef SCCB_INIT_READBACK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ent_d   = ent_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    sub_d   = sub_q;
    data_d  = data_q;
`ifdef SCCB_INIT_READBACK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (init_start) begin
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ent_d = rom_word[15:0];
        unique case (rom_op)
          OP_WR:  state_d = S_ISSUE;
          OP_DLY: begin
            cnt_d   = 32'(rom_word[7:0]) * TICKS_PER_MS;
            state_d = S_DELAY;
          end
          default: state_d = S_DONE;
        endcase
      end
      S_ISSUE: begin
        start_d = 1'b1;
        rw_d    = 1'b0;
        addr_d  = DEV_ADDR;
        sub_d   = ent_q[15:8];
        data_d  = ent_q[7:0];
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (sccb.sccb_done) begin
          start_d = 1'b0;
          cnt_d   = GAP_LOAD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // A zero-length gap still costs the one cycle spent here.
        if (cnt_q <= 32'd1) begin
`ifdef SCCB_INIT_READBACK_EN
          state_d = S_RB_ISSUE;
`else
          idx_d   = idx_q + 5'd1;
          state_d = S_FETCH;
`endif
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_DELAY: begin
        if (cnt_q <= 32'd1) begin
          idx_d   = idx_q + 5'd1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
`ifdef SCCB_INIT_READBACK_EN
      S_RB_ISSUE: begin
        start_d = 1'b1;
        rw_d    = 1'b1;
        addr_d  = DEV_ADDR | 8'h01;
        sub_d   = ent_q[15:8];
        state_d = S_RB_WAIT;
      end
      S_RB_WAIT: begin
        if (sccb.sccb_done) begin
          start_d = 1'b0;
          if (sccb.sccb_data_out != ent_q[7:0] && err_q != 8'hFF) err_d = err_q + 8'd1;
          cnt_d   = GAP_LOAD;
          state_d = S_RB_GAP;
        end
      end
      S_RB_GAP: begin
        if (cnt_q <= 32'd1) begin
          idx_d   = idx_q + 5'd1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SCCB_INIT_READBACK_EN
  assign err_cnt = err_q;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^sccb.sccb_data_out;
  assign err_cnt        = 8'd0;
`endif

  assign init_busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign init_done          = (state_q == S_DONE);
  assign dbg_state_o        = state_q;
  assign sccb.sccb_start    = start_q;
  assign sccb.sccb_rw       = rw_q;
  assign sccb.sccb_ip_addr  = addr_q;
  assign sccb.sccb_sub_addr = sub_q;
  assign sccb.sccb_data_in  = data_q;

endmodule
